tap_tms_driver: RTL

//  Initiator side of the TAP: drives TMS_Pad so a downstream TAP controller walks to a requested state.

---
 rtl/tap_pkg.sv | 100 ++++++++++
 rtl/tap_shadow.sv | 67 ++++++
 rtl/tap_tms_driver.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// Purpose: shared TAP definitions. Holds the 4-bit state encoding, the driver
//          FSM state type, and the helper functions: stability test, self-loop
//          TMS value, the TAP next-state table and the shortest-path router.
// Ports:   none (package).
package tap_pkg;

    localparam logic [3:0] TLR    = 4'hF;
    localparam logic [3:0] RTI    = 4'hC;
    localparam logic [3:0] SEL_DR = 4'h7;
    localparam logic [3:0] CAP_DR = 4'h6;
    localparam logic [3:0] SH_DR  = 4'h2;
    localparam logic [3:0] EX1_DR = 4'h1;
    localparam logic [3:0] PAU_DR = 4'h3;
    localparam logic [3:0] EX2_DR = 4'h0;
    localparam logic [3:0] UPD_DR = 4'h5;
    localparam logic [3:0] SEL_IR = 4'h4;
    localparam logic [3:0] CAP_IR = 4'hE;
    localparam logic [3:0] SH_IR  = 4'hA;
    localparam logic [3:0] EX1_IR = 4'h9;
    localparam logic [3:0] PAU_IR = 4'hB;
    localparam logic [3:0] EX2_IR = 4'h8;
    localparam logic [3:0] UPD_IR = 4'hD;

    localparam int FORCE_LEN = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FORCE,
        ST_STEP,
        ST_HOLD,
        ST_DONE
    } drv_state_e;

    // States with a self-loop; only these may be requested as targets.
    function automatic logic is_stable(input logic [3:0] s);
        return (s == TLR) || (s == RTI) || (s == SH_DR) || (s == PAU_DR) ||
               (s == SH_IR) || (s == PAU_IR);
    endfunction

    // TMS that keeps the TAP where it is. A non-stable state has no such
    // value; 1 is used so the TAP drifts toward TLR instead of into a scan.
    function automatic logic self_loop_tms(input logic [3:0] s);
        return (s == TLR) || !is_stable(s);
    endfunction

    function automatic logic is_ir_side(input logic [3:0] s);
        return (s == SEL_IR) || (s == CAP_IR) || (s == SH_IR) || (s == EX1_IR) ||
               (s == PAU_IR) || (s == EX2_IR) || (s == UPD_IR);
    endfunction

    function automatic logic [3:0] next_state(input logic [3:0] cur, input logic tms);
        logic [3:0] n;
        case (cur)
            TLR:     n = tms ? TLR    : RTI;
            RTI:     n = tms ? SEL_DR : RTI;
            SEL_DR:  n = tms ? SEL_IR : CAP_DR;
            CAP_DR:  n = tms ? EX1_DR : SH_DR;
            SH_DR:   n = tms ? EX1_DR : SH_DR;
            EX1_DR:  n = tms ? UPD_DR : PAU_DR;
            PAU_DR:  n = tms ? EX2_DR : PAU_DR;
            EX2_DR:  n = tms ? UPD_DR : SH_DR;
            UPD_DR:  n = tms ? SEL_DR : RTI;
            SEL_IR:  n = tms ? TLR    : CAP_IR;
            CAP_IR:  n = tms ? EX1_IR : SH_IR;
            SH_IR:   n = tms ? EX1_IR : SH_IR;
            EX1_IR:  n = tms ? UPD_IR : PAU_IR;
            PAU_IR:  n = tms ? EX2_IR : PAU_IR;
            EX2_IR:  n = tms ? UPD_IR : SH_IR;
            default: n = tms ? SEL_DR : RTI;   // UPD_IR
        endcase
        return n;
    endfunction

    // One step of the shortest path from cur toward tgt. The scan-column
    // states compare against the Sh/Pau/Ex1/Ex2 of cur's own column, so a
    // target in the other column always leaves through Update.
    function automatic logic route_tms(input logic [3:0] cur, input logic [3:0] tgt);
        logic       ir;
        logic [3:0] sh, pau, ex1, ex2;
        logic       r;
        ir  = is_ir_side(cur);
        sh  = ir ? SH_IR  : SH_DR;
        pau = ir ? PAU_IR : PAU_DR;
        ex1 = ir ? EX1_IR : EX1_DR;
        ex2 = ir ? EX2_IR : EX2_DR;
        case (cur)
            TLR:                        r = (tgt == TLR);
            RTI:                        r = (tgt != RTI);
            SEL_DR:                     r = is_ir_side(tgt) || (tgt == TLR);
            SEL_IR:                     r = (tgt == TLR);
            CAP_DR, CAP_IR:             r = (tgt != sh);
            SH_DR, SH_IR, PAU_DR, PAU_IR: r = (tgt != cur);
            EX1_DR, EX1_IR:             r = !((tgt == pau) || (tgt == ex2) || (tgt == sh));
            EX2_DR, EX2_IR:             r = !((tgt == sh) || (tgt == ex1) || (tgt == pau));
            default:                    r = (tgt != RTI);   // UPD_DR, UPD_IR
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tap_shadow.sv
// Purpose: shadow copy of the downstream TAP state. Advances on every clock
//          with the TMS value being driven, delays the shadow by OBS_LAT
//          cycles to line it up with the TAP's observed state, and keeps a
//          sticky flag when the two ever disagree.
// Ports:   clk_i, rst_ni     clock, async active-low reset
//          tms_i             TMS currently on the pad
//          mis_clr_i         restart the sticky mismatch flag
//          obs_i             observed TAP state
//          shadow_o          shadow state register
//          shadow_d_o        shadow state after the coming edge
//          mismatch_o        sticky divergence flag
module tap_shadow
    import tap_pkg::*;
#(
    parameter int OBS_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tms_i,
    input  logic       mis_clr_i,
    input  logic [3:0] obs_i,
    output logic [3:0] shadow_o,
    output logic [3:0] shadow_d_o,
    output logic       mismatch_o
);

    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic [3:0] obs_ref;
    logic       mismatch_q;

    assign shadow_d = next_state(shadow_q, tms_i);

    generate
        if (OBS_LAT == 0) begin : g_no_dly
            assign obs_ref = shadow_q;
        end else begin : g_dly
            logic [3:0] dly_q [OBS_LAT];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < OBS_LAT; i++) dly_q[i] <= TLR;
                end else begin
                    dly_q[0] <= shadow_q;
                    for (int i = 1; i < OBS_LAT; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign obs_ref = dly_q[OBS_LAT-1];
        end
    endgenerate

    // A clear restarts the flag from this cycle's comparison so a divergence
    // seen on the clearing edge itself is not lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q   <= TLR;
            mismatch_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            mismatch_q <= (mismatch_q && !mis_clr_i) || (obs_ref != obs_i);
        end
    end

    assign shadow_o   = shadow_q;
    assign shadow_d_o = shadow_d;
    assign mismatch_o = mismatch_q;

endmodule

// File: rtl/tap_tms_driver.sv
// Purpose: TAP initiator. Accepts a target-state request, drives TMS along the
//          shortest legal path (or five ones for TLR), dwells req_hold cycles
//          in the target, then pulses done. Rejected targets and watchdog
//          aborts pulse err.
// Ports:   GCLK_Pad, TRST_Pad    clock, async active-low reset
//          req_valid/req_ready   request handshake
//          req_target, req_hold  target state and extra dwell cycles
//          TMS_Pad               registered TMS to the TAP
//          state_obs_in          TAP state feedback
//          shadow_state          shadow TAP state
//          busy, done, err       status (done/err are 1-cycle pulses)
//          mismatch              sticky feedback divergence
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE; the requester keeps req_valid and its payload
// stable until that edge and may drop them afterwards.
module tap_tms_driver
    import tap_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int HOLD_W    = 8,
    parameter int OBS_LAT   = 1
) (
    input  logic              GCLK_Pad,
    input  logic              TRST_Pad,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_target,
    input  logic [HOLD_W-1:0] req_hold,
    output logic              TMS_Pad,
    input  logic [3:0]        state_obs_in,
    output logic [3:0]        shadow_state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mismatch
);

    localparam int CNT_W = $clog2(MAX_STEPS + FORCE_LEN + 1);

    drv_state_e        state_q;
    logic [3:0]        tgt_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              tms_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [3:0]        shadow_q;
    logic [3:0]        shadow_d;
    logic              accept;

    assign accept = req_valid && ready_q;

    tap_shadow #(
        .OBS_LAT (OBS_LAT)
    ) u_shadow (
        .clk_i      (GCLK_Pad),
        .rst_ni     (TRST_Pad),
        .tms_i      (tms_q),
        .mis_clr_i  (accept),
        .obs_i      (state_obs_in),
        .shadow_o   (shadow_q),
        .shadow_d_o (shadow_d),
        .mismatch_o (mismatch)
    );

    // tms_q is the value for the coming cycle, so every branch computes it from
    // shadow_d (where the TAP will be after this edge). By default it holds
    // the TAP in place.
    always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
        if (!TRST_Pad) begin
            state_q <= ST_IDLE;
            tgt_q   <= TLR;
            hold_q  <= '0;
            cnt_q   <= '0;
            tms_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tms_q  <= self_loop_tms(shadow_d);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_q  <= req_target;
                        hold_q <= req_hold;
                        cnt_q  <= '0;
                        if (req_target == TLR) begin
                            state_q <= ST_FORCE;
                            tms_q   <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (!is_stable(req_target)) begin
                            err_q <= 1'b1;
                        end else if (req_target != shadow_d) begin
                            state_q <= ST_STEP;
                            tms_q   <= route_tms(shadow_d, req_target);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (req_hold != '0) begin
                            state_q <= ST_HOLD;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                ST_FORCE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(FORCE_LEN - 1)) begin
                        if (hold_q != '0) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tms_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (shadow_d == tgt_q) begin
                        if (hold_q != '0) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (cnt_q == CNT_W'(MAX_STEPS - 1)) begin
                        // Watchdog: the shadow keeps tracking, only the request is dropped.
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tms_q <= route_tms(shadow_d, tgt_q);
                    end
                end
                ST_HOLD: begin
                    hold_q <= hold_q - 1'b1;
                    if (hold_q == HOLD_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = ready_q;
    assign TMS_Pad      = tms_q;
    assign shadow_state = shadow_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
